// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the adder family.
// Holds the half-adder result pair and its single-bit evaluator.
package arith_pkg;

    localparam int COUNT_W_DEF = 16;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_t;

    function automatic ha_t ha_bit(
        input logic a,
        input logic b
    );
        ha_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half-adder lane.
// Leaf cell replicated per lane by half_adder.
module half_adder_cell
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_t r;

    always_comb begin
        r     = ha_bit(a, b);
        sum   = r.sum;
        carry = r.carry;
    end

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane half adder with valid qualification and carry-event counter.
// Define HALF_ADDER_PIPE_EN to register sum, carry and out_valid.
module half_adder
    import arith_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    output logic [WIDTH-1:0]   sum,
    output logic [WIDTH-1:0]   carry,
    output logic [COUNT_W-1:0] carry_count
);

    logic [WIDTH-1:0] s_c;
    logic [WIDTH-1:0] c_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (s_c[i]),
            .carry (c_c[i])
        );
    end

    // At most one increment per accepted pair, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_count <= '0;
        end else if (in_valid && (|c_c) && (carry_count != '1)) begin
            carry_count <= carry_count + COUNT_W'(1);
        end
    end

`ifdef HALF_ADDER_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= s_c;
                carry <= c_c;
            end
        end
    end
`else
    always_comb begin
        out_valid = in_valid;
        sum       = s_c;
        carry     = c_c;
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder in either datapath mode.
// Reference model works lane-by-lane with integer addition.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       a1;
    logic       b1;
    logic [3:0] a4;
    logic [3:0] b4;

    logic        ov1, ov4, ovs;
    logic        s1, c1;
    logic [3:0]  s4, c4, ss, cs;
    logic [15:0] cnt1, cnt4;
    logic [1:0]  cnts;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int  m_cnt1 = 0;
    int  m_cnt4 = 0;
    int  m_cnts = 0;
    bit  started = 0;

    logic       p_ov = 1'b0;
    logic [3:0] p_s1 = '0, p_c1 = '0;
    logic [3:0] p_s4 = '0, p_c4 = '0;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a1), .b(b1),
        .out_valid(ov1), .sum(s1), .carry(c1),
        .carry_count(cnt1)
    );

    half_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a4), .b(b4),
        .out_valid(ov4), .sum(s4), .carry(c4),
        .carry_count(cnt4)
    );

    half_adder #(.WIDTH(4), .COUNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a4), .b(b4),
        .out_valid(ovs), .sum(ss), .carry(cs),
        .carry_count(cnts)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_sum(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            r[i] = (t % 2) == 1;
        end
        return r;
    endfunction

    function automatic logic [3:0] m_carry(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            r[i] = (t / 2) == 1;
        end
        return r;
    endfunction

    function automatic int bump(input int c, input int maxv);
        return (c < maxv) ? c + 1 : c;
    endfunction

    task automatic step(input logic r, input logic iv,
                        input logic x1, input logic y1,
                        input logic [3:0] x4, input logic [3:0] y4);
        logic [3:0] w1s, w1c, w4s, w4c;
        @(negedge clk);
        rst = r; in_valid = iv;
        a1 = x1; b1 = y1; a4 = x4; b4 = y4;
        #1;
        if (started) begin
`ifdef HALF_ADDER_PIPE_EN
            chk("ov1", 32'(ov1), 32'(p_ov));
            chk("ov4", 32'(ov4), 32'(p_ov));
            chk("ovs", 32'(ovs), 32'(p_ov));
            chk("sum1", 32'(s1), 32'(p_s1[0]));
            chk("carry1", 32'(c1), 32'(p_c1[0]));
            chk("sum4", 32'(s4), 32'(p_s4));
            chk("carry4", 32'(c4), 32'(p_c4));
            chk("sums", 32'(ss), 32'(p_s4));
            chk("carrys", 32'(cs), 32'(p_c4));
`else
            chk("ov1", 32'(ov1), 32'(iv));
            chk("ov4", 32'(ov4), 32'(iv));
            if (iv) begin
                chk("sum1", 32'(s1), 32'(m_sum({3'b0, x1}, {3'b0, y1}) & 4'h1));
                chk("carry1", 32'(c1), 32'(m_carry({3'b0, x1}, {3'b0, y1}) & 4'h1));
                chk("sum4", 32'(s4), 32'(m_sum(x4, y4)));
                chk("carry4", 32'(c4), 32'(m_carry(x4, y4)));
                chk("sums", 32'(ss), 32'(m_sum(x4, y4)));
            end
`endif
            chk("cnt1", 32'(cnt1), 32'(m_cnt1));
            chk("cnt4", 32'(cnt4), 32'(m_cnt4));
            chk("cnts", 32'(cnts), 32'(m_cnts));
        end
        @(posedge clk);
        started = 1;
        if (r) begin
            m_cnt1 = 0; m_cnt4 = 0; m_cnts = 0;
            p_ov = 1'b0;
            p_s1 = '0; p_c1 = '0; p_s4 = '0; p_c4 = '0;
        end else begin
            p_ov = iv;
            if (iv) begin
                w1s = m_sum({3'b0, x1}, {3'b0, y1});
                w1c = m_carry({3'b0, x1}, {3'b0, y1});
                w4s = m_sum(x4, y4);
                w4c = m_carry(x4, y4);
                if (w1c != 0) m_cnt1 = bump(m_cnt1, 65535);
                if (w4c != 0) begin
                    m_cnt4 = bump(m_cnt4, 65535);
                    m_cnts = bump(m_cnts, 3);
                end
                p_s1 = w1s; p_c1 = w1c; p_s4 = w4s; p_c4 = w4c;
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;

        step(1, 0, 0, 0, 4'h0, 4'h0);
        step(1, 1, 1, 1, 4'hF, 4'hF);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        chk("rst_cnt", 32'(cnt4), 32'd0);

        // WIDTH=1 sweep alongside the 1100/1010 pattern
        step(0, 1, 0, 0, 4'hC, 4'hA);
        step(0, 1, 0, 1, 4'hC, 4'hA);
        step(0, 1, 1, 0, 4'hC, 4'hA);
        step(0, 1, 1, 1, 4'hC, 4'hA);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        chk("sweep_cnt1", 32'(cnt1), 32'd1);
        chk("sweep_cnt4", 32'(cnt4), 32'd4);

        step(0, 1, 0, 0, 4'hF, 4'hF);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        chk("all_carry_cnt4", 32'(cnt4), 32'd5);

        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 4'hF, 4'hF);
        chk("idle_cnt4", 32'(cnt4), 32'd5);
        chk("idle_ov", 32'(ov4), 32'd0);

        step(0, 0, 1'bx, 1'bx, 4'bx, 4'bx);
        step(0, 0, 1'bx, 1'bx, 4'bx, 4'bx);

        step(1, 0, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 4'h8, 4'h8);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        chk("sat_cnts", 32'(cnts), 32'd3);
        chk("nosat_cnt4", 32'(cnt4), 32'd6);

        step(0, 1, 1, 1, 4'h1, 4'h1);
        step(0, 1, 1, 1, 4'h1, 4'h1);
        step(1, 1, 1, 1, 4'h1, 4'h1);
        step(0, 1, 1, 1, 4'h1, 4'h1);
        chk("rst_mid_cnt1", 32'(cnt1), 32'd0);
`ifdef HALF_ADDER_PIPE_EN
        chk("rst_mid_ov", 32'(ov1), 32'd0);
`endif
        step(0, 0, 0, 0, 4'h0, 4'h0);
        chk("post_rst_cnt1", 32'(cnt1), 32'd1);

        step(0, 1, 1, 1, 4'h0, 4'h0);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        step(0, 0, 0, 0, 4'h0, 4'h0);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 19) == 0, 1'($urandom),
                 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end
        step(0, 0, 0, 0, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
